serial_lu: RTL and testbench

//  Bit-serial logic unit. Operands enter as WIDTH-bit words. Each cycle the unit

---
 rtl/serial_lu_pkg.sv | 15 +
 rtl/serial_lu_cl.sv | 22 ++
 rtl/serial_lu.sv | 95 +++++++++
 tb/tb_serial_lu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/serial_lu_pkg.sv
// Shared definitions for the bit-serial logic unit: cell opcodes and FSM states.
package lu_defs;

    localparam logic [1:0] CLOP_AND  = 2'b00;
    localparam logic [1:0] CLOP_OR   = 2'b01;
    localparam logic [1:0] CLOP_XOR  = 2'b10;
    localparam logic [1:0] CLOP_NOTA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } lu_state_t;

endpackage

// File: rtl/serial_lu_cl.sv
// 1-bit combinational logic cell: AND / OR / XOR / NOT a, selected by clop.
module cl
    import lu_defs::*;
(
    output logic       out,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] clop
);

    always_comb begin
        out = 1'b0;
        case (clop)
            CLOP_AND:  out = a & b;
            CLOP_OR:   out = a | b;
            CLOP_XOR:  out = a ^ b;
            CLOP_NOTA: out = ~a;
            default:   out = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_lu.sv
// Bit-serial logic unit: latches operands on start, feeds cl one bit pair per
// cycle LSB first, and shifts cl's output into result from the top.
module serial_lu
    import lu_defs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       clop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    lu_state_t        state;
    lu_state_t        state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             cell_out;

    cl u_cl (
        .out  (cell_out),
        .a    (sa[0]),
        .b    (sb[0]),
        .clop (op)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sa     <= '0;
            sb     <= '0;
            op     <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        op     <= clop;
                        cnt    <= '0;
                        result <= '0;
                    end
                end
                S_RUN: begin
                    result <= {cell_out, result[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_lu.sv
// Self-checking bench for serial_lu: directed cases plus randomized ops
// compared against a word-level reference of the logic function and timing.
module tb_serial_lu;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   clop;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    serial_lu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .clop    (clop),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_lu(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~x;
        endcase
    endfunction

    // One op: busy for W cycles after acceptance, then a single done cycle,
    // then idle with result held. In noisy mode inputs churn while running.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                          input bit noisy, input logic [W-1:0] exp);
        @(negedge clk);
        start = 1'b1; a = x; b = y; clop = o;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            if (k <= int'(W)) begin
                check("busy_run", 32'(busy), 32'd1);
                check("done_in_run", 32'(done), 32'd0);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_in_done", 32'(busy), 32'd0);
                check("result_done", 32'(result), 32'(exp));
            end
            if (noisy) begin
                a     = W'($urandom);
                b     = W'($urandom);
                clop  = 2'($urandom_range(3));
                start = 1'($urandom_range(1));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(exp));
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic [1:0]   o;
        bit           noisy;

        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; clop = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        reset_n = 1'b1;

        run_op(8'hF0, 8'hAA, 2'b00, 1'b0, 8'hA0);
        run_op(8'hF0, 8'hAA, 2'b01, 1'b0, 8'hFA);
        run_op(8'hF0, 8'hAA, 2'b10, 1'b0, 8'h5A);
        run_op(8'hF0, 8'hAA, 2'b11, 1'b0, 8'h0F);

        // A second request arriving mid-run must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h0F; clop = 2'b00;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            if (k == int'(W) + 1) begin
                check("ignore_done", 32'(done), 32'd1);
                check("ignore_result", 32'(result), 32'h0F);
            end
            start = (k == 3);
            if (k == 3) begin
                a = 8'h00; clop = 2'b01;
            end
        end
        start = 1'b0;
        @(negedge clk);

        run_op(8'h81, 8'h81, 2'b00, 1'b1, 8'h81);

        // Reset mid-run aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'hAA; clop = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'hF0, 8'hAA, 2'b00, 1'b0, 8'hA0);

        // Start held high: one op every W+2 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h3C; b = 8'hC3; clop = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((k % 10) == 9));
            check("b2b_busy", 32'(busy), 32'(((k % 10) >= 1) && ((k % 10) <= 8)));
            if ((k % 10) == 9) check("b2b_result", 32'(result), 32'hFF);
            if (k == 30) start = 1'b0;
        end

        repeat (40) begin
            x     = W'($urandom);
            y     = W'($urandom);
            o     = 2'($urandom_range(3));
            noisy = 1'($urandom_range(1));
            run_op(x, y, o, noisy, ref_lu(x, y, o));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
